// File: rtl/demux14_stream_if.sv
// Stream bundle for the 1-to-4 demux.
// Producer side plus four consumer channels and the accept counter.
interface demux14_stream_if #(
  parameter int W  = 8,
  parameter int CW = 8
);
  logic [W-1:0]  d;
  logic [1:0]    s;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  y1;
  logic [W-1:0]  y2;
  logic [W-1:0]  y3;
  logic [W-1:0]  y4;
  logic          y1_valid;
  logic          y2_valid;
  logic          y3_valid;
  logic          y4_valid;
  logic          y1_ready;
  logic          y2_ready;
  logic          y3_ready;
  logic          y4_ready;
  logic [CW-1:0] xfer_cnt;

  modport slave (
    input  d, s, in_valid,
    input  y1_ready, y2_ready,
    input  y3_ready, y4_ready,
    output in_ready,
    output y1, y2, y3, y4,
    output y1_valid, y2_valid,
    output y3_valid, y4_valid,
    output xfer_cnt
  );

  modport master (
    output d, s, in_valid,
    output y1_ready, y2_ready,
    output y3_ready, y4_ready,
    input  in_ready,
    input  y1, y2, y3, y4,
    input  y1_valid, y2_valid,
    input  y3_valid, y4_valid,
    input  xfer_cnt
  );
endinterface

// File: rtl/demux14_stream.sv
// Registered 1-to-4 stream demux.
// One holding register per channel; a stalled channel blocks only itself.
module demux14_stream #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input logic             clk,
  input logic             rst_n,
  demux14_stream_if.slave bus
);

  logic [W-1:0]  y_q [4];
  logic [W-1:0]  y_d [4];
  logic [3:0]    vld_q;
  logic [3:0]    vld_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    rdy;
  logic          in_ready;
  logic          acc;

  assign rdy = {bus.y4_ready, bus.y3_ready,
                bus.y2_ready, bus.y1_ready};

  // Ready looks only at the selected channel, never at in_valid
  always_comb begin
    in_ready = !vld_q[bus.s] || rdy[bus.s];
    acc      = bus.in_valid && in_ready;
  end

  // Per-channel next state: write wins over drain, so no bubble
  always_comb begin
    cnt_d = cnt_q + CW'(acc);
    for (int i = 0; i < 4; i++) begin
      y_d[i]   = y_q[i];
      vld_d[i] = vld_q[i];
      if (acc && bus.s == 2'(i)) begin
        y_d[i]   = bus.d;
        vld_d[i] = 1'b1;
      end else if (vld_q[i] && rdy[i]) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  // Channel registers and accept counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) y_q[i] <= y_d[i];
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y1       = y_q[0];
  assign bus.y2       = y_q[1];
  assign bus.y3       = y_q[2];
  assign bus.y4       = y_q[3];
  assign bus.y1_valid = vld_q[0];
  assign bus.y2_valid = vld_q[1];
  assign bus.y3_valid = vld_q[2];
  assign bus.y4_valid = vld_q[3];
  assign bus.xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux14_stream.sv
// Directed bench for demux14_stream.
// Vector table plus hand-written multi-cycle sequences.
module tb_demux14_stream;

  logic clk;
  logic rst_n;

  demux14_stream_if #(.W(8), .CW(8)) b8 ();
  demux14_stream_if #(.W(8), .CW(4)) b4 ();

  demux14_stream #(.W(8), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  demux14_stream #(.W(8), .CW(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  assign b4.d        = b8.d;
  assign b4.s        = b8.s;
  assign b4.in_valid = b8.in_valid;
  assign b4.y1_ready = b8.y1_ready;
  assign b4.y2_ready = b8.y2_ready;
  assign b4.y3_ready = b8.y3_ready;
  assign b4.y4_ready = b8.y4_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ya [4];
  logic [3:0] vm;
  always_comb begin
    ya[0] = b8.y1;
    ya[1] = b8.y2;
    ya[2] = b8.y3;
    ya[3] = b8.y4;
    vm = {b8.y4_valid, b8.y3_valid,
          b8.y2_valid, b8.y1_valid};
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d,
                       input logic [1:0] s,
                       input logic iv,
                       input logic [3:0] r);
    b8.d        = d;
    b8.s        = s;
    b8.in_valid = iv;
    b8.y1_ready = r[0];
    b8.y2_ready = r[1];
    b8.y3_ready = r[2];
    b8.y4_ready = r[3];
  endtask

  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
    logic       iv;
    logic [3:0] rdy;
    logic       ir;
    logic [3:0] vld;
    logic [1:0] ch;
    logic [7:0] y;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // routing, all consumers ready
    tbl[0]  = '{8'h11, 2'd0, 1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 8'h11, 8'd1};
    tbl[1]  = '{8'h22, 2'd1, 1'b1, 4'hF, 1'b1, 4'b0010, 2'd1, 8'h22, 8'd2};
    tbl[2]  = '{8'h33, 2'd2, 1'b1, 4'hF, 1'b1, 4'b0100, 2'd2, 8'h33, 8'd3};
    tbl[3]  = '{8'h44, 2'd3, 1'b1, 4'hF, 1'b1, 4'b1000, 2'd3, 8'h44, 8'd4};
    tbl[4]  = '{8'h99, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 8'h11, 8'd4};
    // backpressure on Y2
    tbl[5]  = '{8'hA5, 2'd1, 1'b1, 4'hD, 1'b1, 4'b0010, 2'd1, 8'hA5, 8'd5};
    tbl[6]  = '{8'h5A, 2'd1, 1'b1, 4'hD, 1'b0, 4'b0010, 2'd1, 8'hA5, 8'd5};
    tbl[7]  = '{8'h5A, 2'd1, 1'b1, 4'hF, 1'b1, 4'b0010, 2'd1, 8'h5A, 8'd6};
    tbl[8]  = '{8'h00, 2'd1, 1'b0, 4'hF, 1'b1, 4'b0000, 2'd1, 8'h5A, 8'd6};
    // isolation: Y3 stalled full, stream to Y1
    tbl[9]  = '{8'hC3, 2'd2, 1'b1, 4'hB, 1'b1, 4'b0100, 2'd2, 8'hC3, 8'd7};
    tbl[10] = '{8'h01, 2'd0, 1'b1, 4'hB, 1'b1, 4'b0101, 2'd0, 8'h01, 8'd8};
    tbl[11] = '{8'h02, 2'd0, 1'b1, 4'hB, 1'b1, 4'b0101, 2'd0, 8'h02, 8'd9};
    tbl[12] = '{8'h03, 2'd0, 1'b1, 4'hB, 1'b1, 4'b0101, 2'd0, 8'h03, 8'd10};
    tbl[13] = '{8'h00, 2'd2, 1'b0, 4'hB, 1'b0, 4'b0100, 2'd2, 8'hC3, 8'd10};
    tbl[14] = '{8'h00, 2'd2, 1'b0, 4'hF, 1'b1, 4'b0000, 2'd2, 8'hC3, 8'd10};

    // reset held low while inputs toggle
    rst_n = 1'b0;
    drive(8'h00, 2'd0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      drive(8'(8'h5C + i), 2'(i), 1'b1, 4'(i));
    end
    @(negedge clk);
    chk("rst_vld", 32'(vm), 32'h0);
    chk("rst_cnt", 32'(b8.xfer_cnt), 32'h0);
    chk("rst_cnt4", 32'(b4.xfer_cnt), 32'h0);
    for (int c = 0; c < 4; c++)
      chk($sformatf("rst_y%0d", c + 1), 32'(ya[c]), 32'h0);
    drive(8'h00, 2'd0, 1'b0, 4'h0);
    rst_n = 1'b1;

    // table vectors
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].d, tbl[i].s, tbl[i].iv, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d_in_ready", i),
          32'(b8.in_ready), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), 32'(vm), 32'(tbl[i].vld));
      chk($sformatf("v%0d_y", i),
          32'(ya[tbl[i].ch]), 32'(tbl[i].y));
      chk($sformatf("v%0d_cnt", i),
          32'(b8.xfer_cnt), 32'(tbl[i].cnt));
    end

    // streaming 16 words to Y4, no bubbles
    for (int i = 0; i < 16; i++) begin
      drive(8'(8'h40 + i * 3), 2'd3, 1'b1, 4'hF);
      #1;
      chk("strm_in_ready", 32'(b8.in_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("strm_y4_valid", 32'(b8.y4_valid), 32'h1);
      chk("strm_y4", 32'(b8.y4), 32'(8'(8'h40 + i * 3)));
    end
    drive(8'h00, 2'd3, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    chk("strm_end_vld", 32'(vm), 32'h0);
    chk("strm_cnt", 32'(b8.xfer_cnt), 32'd26);

    // async reset mid-stream drops a held word
    drive(8'h77, 2'd1, 1'b1, 4'hD);
    @(posedge clk);
    #1;
    chk("pre_rst_y2v", 32'(b8.y2_valid), 32'h1);
    chk("pre_rst_y2", 32'(b8.y2), 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(vm), 32'h0);
    chk("arst_y2", 32'(b8.y2), 32'h0);
    chk("arst_cnt", 32'(b8.xfer_cnt), 32'h0);
    drive(8'h00, 2'd0, 1'b0, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // counter wrap: 17 accepts, 4-bit counter reads 1
    @(posedge clk);
    #1;
    drive(8'hE1, 2'd0, 1'b1, 4'hF);
    repeat (17) @(posedge clk);
    #1;
    drive(8'h00, 2'd0, 1'b0, 4'hF);
    chk("wrap_cnt4", 32'(b4.xfer_cnt), 32'd1);
    chk("wrap_cnt8", 32'(b8.xfer_cnt), 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
